// File: rtl/decimal_entry_0_19_pkg.sv
// decimal_entry_0_19_pkg: shared encodings and digit arithmetic for the 0-19 operand entry unit.
`default_nettype none

package decimal_entry_0_19_pkg;

  typedef enum logic [1:0] {
    ST_TENS  = 2'b00,
    ST_UNITS = 2'b01,
    ST_HOLD  = 2'b10
  } entry_state_t;

  localparam int unsigned MAX_OPERAND = 19;
  localparam int unsigned UNITS_WRAP  = 9;
  localparam int unsigned OPERAND_W   = $clog2(MAX_OPERAND + 1);
  localparam int unsigned UNITS_W     = $clog2(UNITS_WRAP + 1);

  function automatic logic [OPERAND_W-1:0] operand_value(
    input logic               tens,
    input logic [UNITS_W-1:0] units
  );
    logic [OPERAND_W-1:0] w_units_ext;
    w_units_ext = OPERAND_W'(units);
    return tens ? (OPERAND_W'(10) + w_units_ext) : w_units_ext;
  endfunction

  function automatic logic [UNITS_W-1:0] next_units(input logic [UNITS_W-1:0] units);
    return (units == UNITS_W'(UNITS_WRAP)) ? '0 : units + UNITS_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decimal_entry_0_19_if.sv
// decimal_entry_0_19_if: valid/ready operand handshake toward the processor datapath.
`default_nettype none

interface decimal_entry_0_19_if;
  import decimal_entry_0_19_pkg::*;

  logic [OPERAND_W-1:0] value_out;
  logic                 value_valid;
  logic                 value_ready;

  modport master (
    output value_out,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_out,
    input  value_valid,
    output value_ready
  );
endinterface

`default_nettype wire

// File: rtl/decimal_entry_0_19_key_debounce.sv
// key_debounce: 2-FF synchronizer, optional debounce counter (ENTRY_DEBOUNCE_EN), rising-edge pulse.
`default_nettype none

module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_key_n,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic w_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync1   <= ~i_key_n;
      r_sync2   <= r_sync1;
      r_level_d <= w_level;
    end
  end

`ifdef ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_level = r_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES > 1);
  assign w_level      = r_sync2;
`endif

  assign o_pulse = w_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/decimal_entry_0_19.sv
// decimal_entry_0_19: two-digit (0-19) operand entry FSM with valid/ready output.
// Debounce counters are enabled by defining ENTRY_DEBOUNCE_EN.
`default_nettype none

module decimal_entry_0_19
  import decimal_entry_0_19_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  wire                       clk,
  input  wire                       reset,
  input  wire                       key_inc_n,
  input  wire                       key_next_n,
  input  wire                       key_clr_n,
  decimal_entry_0_19_if.master      entry_bus,
  output logic                      tens_digit,
  output logic [UNITS_W-1:0]        units_digit,
  output logic [1:0]                entry_state
);

  logic w_inc_p;
  logic w_next_p;
  logic w_clr_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (key_inc_n),
    .o_pulse (w_inc_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (key_next_n),
    .o_pulse (w_next_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (key_clr_n),
    .o_pulse (w_clr_p)
  );

  entry_state_t         r_state;
  logic                 r_tens;
  logic [UNITS_W-1:0]   r_units;
  logic [OPERAND_W-1:0] r_value;
  logic                 r_valid;

  // Priority: reset > clear > next > inc; losing pulses are simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_TENS;
      r_tens  <= 1'b0;
      r_units <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else if (w_clr_p) begin
      r_state <= ST_TENS;
      r_tens  <= 1'b0;
      r_units <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_TENS: begin
          if (w_next_p) begin
            r_state <= ST_UNITS;
          end else if (w_inc_p) begin
            r_tens <= ~r_tens;
          end
        end
        ST_UNITS: begin
          if (w_next_p) begin
            r_value <= operand_value(r_tens, r_units);
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else if (w_inc_p) begin
            r_units <= next_units(r_units);
          end
        end
        ST_HOLD: begin
          // Digits are kept so the next entry starts from this operand.
          if (r_valid && entry_bus.value_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_TENS;
          end
        end
        default: begin
          r_state <= ST_TENS;
        end
      endcase
    end
  end

  assign entry_bus.value_out   = r_value;
  assign entry_bus.value_valid = r_valid;
  assign tens_digit            = r_tens;
  assign units_digit           = r_units;
  assign entry_state           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_decimal_entry_0_19.sv
// tb_decimal_entry_0_19: directed + randomized key sequences checked against a digit-level model.
`default_nettype none

module tb_decimal_entry_0_19;

  localparam int unsigned DEB = 8;
`ifdef ENTRY_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int PRESS_CYC = DEB + 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_inc_n = 1'b1;
  logic key_next_n = 1'b1;
  logic key_clr_n = 1'b1;
  logic       tens_digit;
  logic [3:0] units_digit;
  logic [1:0] entry_state;

  decimal_entry_0_19_if u_if ();

  decimal_entry_0_19 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_inc_n   (key_inc_n),
    .key_next_n  (key_next_n),
    .key_clr_n   (key_clr_n),
    .entry_bus   (u_if),
    .tens_digit  (tens_digit),
    .units_digit (units_digit),
    .entry_state (entry_state)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: operator-visible digits and handshake, state as 0=TENS 1=UNITS 2=HOLD.
  int m_tens, m_units, m_state, m_valid, m_value;

  task automatic m_reset();
    m_tens = 0; m_units = 0; m_state = 0; m_valid = 0; m_value = 0;
  endtask

  task automatic m_keys(input int inc, input int nxt, input int clr);
    if (clr != 0) begin
      m_tens = 0; m_units = 0; m_valid = 0; m_state = 0;
    end else if (m_state == 0) begin
      if (nxt != 0) m_state = 1;
      else if (inc != 0) m_tens = 1 - m_tens;
    end else if (m_state == 1) begin
      if (nxt != 0) begin
        m_value = 10 * m_tens + m_units;
        m_valid = 1;
        m_state = 2;
      end else if (inc != 0) begin
        m_units = (m_units + 1) % 10;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tens"},  32'(tens_digit),        32'(m_tens));
    check({tag, ".units"}, 32'(units_digit),       32'(m_units));
    check({tag, ".state"}, 32'(entry_state),       32'(m_state));
    check({tag, ".valid"}, 32'(u_if.value_valid),  32'(m_valid));
    check({tag, ".value"}, 32'(u_if.value_out),    32'(m_value));
  endtask

  // mask bit0 = inc, bit1 = next, bit2 = clr; all keys go down on the same cycle.
  task automatic press(input logic [2:0] mask, input string tag);
    key_inc_n  = ~mask[0];
    key_next_n = ~mask[1];
    key_clr_n  = ~mask[2];
    tick(PRESS_CYC);
    key_inc_n = 1'b1; key_next_n = 1'b1; key_clr_n = 1'b1;
    tick(PRESS_CYC);
    m_keys(int'(mask[0]), int'(mask[1]), int'(mask[2]));
    check_all(tag);
  endtask

  task automatic ready_pulse(input string tag);
    u_if.value_ready = 1'b1;
    tick(1);
    u_if.value_ready = 1'b0;
    if (m_state == 2 && m_valid == 1) begin
      m_valid = 0;
      m_state = 0;
    end
    check_all(tag);
  endtask

  initial begin
    logic [2:0] w_mask;
    int         r;
    u_if.value_ready = 1'b0;
    m_reset();
    tick(3);
    check_all("reset");
    reset = 1'b0;
    tick(2);

    // Key latency: tens toggles exactly LAT edges after the raw assertion.
    key_inc_n = 1'b0;
    tick(LAT - 1);
    check("lat.before", 32'(tens_digit), 32'd0);
    tick(1);
    check("lat.at", 32'(tens_digit), 32'd1);
    tick(PRESS_CYC);
    key_inc_n = 1'b1;
    tick(PRESS_CYC);
    m_keys(1, 0, 0);
    check_all("lat.held_once");

    // Basic entry to 17, then one-cycle ready.
    press(3'b100, "basic.clr");
    press(3'b001, "basic.inc_t");
    press(3'b010, "basic.next");
    repeat (7) press(3'b001, "basic.inc_u");
    press(3'b010, "basic.next2");
    check("basic.value17", 32'(u_if.value_out), 32'd17);
    ready_pulse("basic.xfer");

    // Units wrap and tens toggle.
    press(3'b100, "wrap.clr");
    press(3'b010, "wrap.next");
    repeat (10) press(3'b001, "wrap.inc");
    press(3'b100, "wrap.back");
    repeat (2) press(3'b001, "wrap.tens2");
    press(3'b010, "wrap.next2");
    repeat (9) press(3'b001, "wrap.inc9");
    press(3'b010, "wrap.load");
    check("wrap.value9", 32'(u_if.value_out), 32'd9);
    ready_pulse("wrap.xfer");

`ifdef ENTRY_DEBOUNCE_EN
    // Bounce shorter than DEB never registers; final stable press gives one increment.
    press(3'b100, "bounce.clr");
    repeat (7) begin
      key_inc_n = 1'b0; tick(3);
      key_inc_n = 1'b1; tick(3);
    end
    check("bounce.none", 32'(tens_digit), 32'd0);
    key_inc_n = 1'b0;
    tick(10);
    check("bounce.t10", 32'(tens_digit), 32'd0);
    tick(1);
    check("bounce.t11", 32'(tens_digit), 32'd1);
    tick(PRESS_CYC);
    key_inc_n = 1'b1;
    tick(PRESS_CYC);
    m_reset();
    m_keys(1, 0, 0);
    check_all("bounce.once");
`endif

    // Coincident clr + next in UNITS with digits 1/5.
    press(3'b100, "coin.clr");
    press(3'b001, "coin.t");
    press(3'b010, "coin.n");
    repeat (5) press(3'b001, "coin.u");
    press(3'b110, "coin.clr_next");
    // In HOLD, inc is ignored with ready low.
    press(3'b001, "coin.t2");
    press(3'b010, "coin.n2");
    press(3'b010, "coin.hold");
    press(3'b001, "coin.hold_inc");

    // Back-pressure: valid and value stay put while ready is low.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("bp.valid", 32'(u_if.value_valid), 32'd1);
      check("bp.value", 32'(u_if.value_out), 32'(m_value));
    end
    ready_pulse("bp.xfer");
    tick(1);
    check_all("bp.after");

    // Reset in HOLD with value 12 while inc is held.
    press(3'b100, "rst.clr");
    press(3'b001, "rst.t");
    press(3'b010, "rst.n");
    repeat (2) press(3'b001, "rst.u");
    press(3'b010, "rst.hold");
    check("rst.value12", 32'(u_if.value_out), 32'd12);
    key_inc_n = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    m_reset();
    check_all("rst.values");
    reset = 1'b0;
    tick(LAT - 1);
    check("rst.no_early_inc", 32'(tens_digit), 32'd0);
    tick(1);
    check("rst.inc_after", 32'(tens_digit), 32'd1);
    key_inc_n = 1'b1;
    tick(PRESS_CYC);
    m_keys(1, 0, 0);
    check_all("rst.settled");

    // Randomized key traffic.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 9) begin
        ready_pulse("rand.ready");
      end else begin
        if (r < 4)      w_mask = 3'b001;
        else if (r < 7) w_mask = 3'b010;
        else if (r < 8) w_mask = 3'b100;
        else            w_mask = 3'($urandom_range(1, 7));
        press(w_mask, "rand.key");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
